// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package ccff_loader_pkg;

    localparam int unsigned CCFF_NUM_CHAINS    = 12;
    localparam int unsigned CCFF_CHAIN_LEN     = 1024;
    localparam int unsigned CCFF_PRESET_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESET,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } ccff_state_t;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready bitstream stream: one bit per configuration chain per transfer.
interface ccff_bitstream_loader_if
    import ccff_loader_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = CCFF_NUM_CHAINS
);

    logic [NUM_CHAINS-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/ccff_bitstream_loader_tail_checker.sv
// Sticky flag raised when any chain tail is nonzero at a sample strobe;
// used only when CCFF_TAIL_CHECK_EN is defined.
module ccff_tail_checker
    import ccff_loader_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = CCFF_NUM_CHAINS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  sample,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  error
);

    logic error_q;
    logic error_d;

    always_comb begin
        error_d = error_q;
        if (clear) begin
            error_d = 1'b0;
        end else if (sample && (ccff_tail != '0)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Shifts a bitstream into all fabric configuration chains in parallel.
// Optional CCFF_TAIL_CHECK_EN: verify chain tails read 0 during the load.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned NUM_CHAINS    = CCFF_NUM_CHAINS,
    parameter int unsigned CHAIN_LEN     = CCFF_CHAIN_LEN,
    parameter int unsigned PRESET_CYCLES = CCFF_PRESET_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    ccff_bitstream_loader_if.slave  cfg,
    output logic                    config_enable,
    output logic                    pReset,
    output logic                    prog_clk,
    output logic [NUM_CHAINS-1:0]   ccff_head,
    input  logic [NUM_CHAINS-1:0]   ccff_tail,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PCNT_W = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CHAIN_LEN);
    localparam logic [PCNT_W-1:0] PRE_LAST = PCNT_W'(PRESET_CYCLES - 1);

    ccff_state_t           state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PCNT_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [NUM_CHAINS-1:0] head_q, head_d;
    logic                  cfg_en_q, cfg_en_d;
    logic                  preset_n_q, preset_n_d;
    logic                  prog_clk_q, prog_clk_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic load_start;
    logic accept;

    assign load_start    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept        = cfg.cfg_valid && (state_q == ST_SHIFT_LO);
    assign cfg.cfg_ready = (state_q == ST_SHIFT_LO);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        head_d    = head_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d   = ST_PRESET;
                    bit_cnt_d = '0;
                    pre_cnt_d = '0;
                end
            end
            ST_PRESET: begin
                if (pre_cnt_q == PRE_LAST) begin
                    state_d = ST_SHIFT_LO;
                end else begin
                    pre_cnt_d = pre_cnt_q + PCNT_W'(1);
                end
            end
            ST_SHIFT_LO: begin
                if (accept) begin
                    head_d    = cfg.cfg_data;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    state_d   = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                state_d = (bit_cnt_q < BIT_LAST) ? ST_SHIFT_LO : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so each registered output
        // lines up with the state it belongs to.
        cfg_en_d   = state_d inside {ST_PRESET, ST_SHIFT_LO, ST_SHIFT_HI};
        busy_d     = cfg_en_d;
        preset_n_d = (state_d != ST_PRESET);
        prog_clk_d = (state_d == ST_SHIFT_HI);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            head_q     <= '0;
            cfg_en_q   <= 1'b0;
            preset_n_q <= 1'b1;
            prog_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            head_q     <= head_d;
            cfg_en_q   <= cfg_en_d;
            preset_n_q <= preset_n_d;
            prog_clk_q <= prog_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign config_enable = cfg_en_q;
    assign pReset        = preset_n_q;
    assign prog_clk      = prog_clk_q;
    assign ccff_head     = head_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef CCFF_TAIL_CHECK_EN
    ccff_tail_checker #(
        .NUM_CHAINS (NUM_CHAINS)
    ) u_tail_checker (
        .clk       (clk),
        .reset     (reset),
        .clear     (load_start),
        .sample    (accept),
        .ccff_tail (ccff_tail),
        .error     (error)
    );
`else
    logic unused_tail;
    assign unused_tail = ^ccff_tail;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomized self-checking bench for ccff_bitstream_loader (NUM_CHAINS=12, CHAIN_LEN=4).
module tb_ccff_bitstream_loader;

    localparam int unsigned NC = 12;
    localparam int unsigned L  = 4;
    localparam int unsigned P  = 8;
`ifdef CCFF_TAIL_CHECK_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          config_enable, pReset, prog_clk, busy, done, error;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail = '0;
    logic [NC-1:0] words [L];

    int n_checks = 0;
    int n_errors = 0;

    ccff_bitstream_loader_if #(.NUM_CHAINS(NC)) cfg_if ();

    ccff_bitstream_loader #(
        .NUM_CHAINS    (NC),
        .CHAIN_LEN     (L),
        .PRESET_CYCLES (P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg           (cfg_if.slave),
        .config_enable (config_enable),
        .pReset        (pReset),
        .prog_clk      (prog_clk),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_en"},   config_enable,    0);
        check({tag, "_preset"},   pReset,           1);
        check({tag, "_prog_clk"}, prog_clk,         0);
        check({tag, "_head"},     ccff_head,        0);
        check({tag, "_ready"},    cfg_if.cfg_ready, 0);
        check({tag, "_busy"},     busy,             0);
        check({tag, "_done"},     done,             0);
        check({tag, "_error"},    error,            0);
    endtask

    // Model: a load is P preset cycles, then two cycles per bit plus one per
    // stalled ready cycle; each prog_clk rise carries the next word in order.
    task automatic run_load(input int stall_at, input int stall_len, input int bad_idx,
                            input logic [NC-1:0] bad_val, input int glitch_cyc,
                            input int abort_pulse);
        int k = 0, pulses = 0, pre_lo = 0, ce_hi = 0, busy_hi = 0, stalls = 0;
        int stall_left;
        bit exp_err = 1'b0, prev_pc = 1'b0, stalled_prev = 1'b0, finished = 1'b0;
        stall_left = stall_len;
        @(negedge clk);
        start = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("start_cfg_en", config_enable, 1);
                check("start_preset", pReset, 0);
                check("start_done_clr", done, 0);
                check("start_err_clr", error, 0);
            end
            if (cyc == int'(P)) begin
                check("preset_release", pReset, 1);
                check("preset_cfg_en", config_enable, 1);
            end
            if (!pReset) pre_lo++;
            if (config_enable) ce_hi++;
            if (busy) busy_hi++;
            if (stalled_prev) check("stall_prog_clk", prog_clk, 0);
            stalled_prev = 1'b0;
            if (prog_clk && !prev_pc) begin
                pulses++;
                if (pulses <= int'(L)) check("head_at_rise", ccff_head, words[pulses-1]);
            end
            prev_pc = prog_clk;

            if (abort_pulse > 0 && pulses == abort_pulse) begin
                start = 1'b0;
                cfg_if.cfg_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                check_reset_values("abort");
                reset = 1'b0;
                finished = 1'b1;
            end else if (!config_enable && ce_hi > 0) begin
                check("end_done", done, 1);
                check("end_prog_clk", prog_clk, 0);
                check("end_preset", pReset, 1);
                check("end_busy", busy, 0);
                check("end_error", error, exp_err);
                check("pulse_count", pulses, L);
                check("preset_len", pre_lo, P);
                check("cfg_en_len", ce_hi, P + 2 * L + stalls);
                check("busy_len", busy_hi, P + 2 * L + stalls);
                finished = 1'b1;
            end else begin
                start = (cyc == glitch_cyc);
                if (cfg_if.cfg_ready && k < int'(L)) begin
                    if (k == stall_at && stall_left > 0) begin
                        cfg_if.cfg_valid = 1'b0;
                        cfg_if.cfg_data  = NC'($urandom);
                        ccff_tail        = NC'($urandom);
                        stall_left--;
                        stalls++;
                        stalled_prev = 1'b1;
                    end else begin
                        cfg_if.cfg_valid = 1'b1;
                        cfg_if.cfg_data  = words[k];
                        if (k == bad_idx) begin
                            ccff_tail = bad_val;
                            exp_err   = TAIL_EN;
                        end else begin
                            ccff_tail = '0;
                        end
                        k++;
                    end
                end else begin
                    cfg_if.cfg_valid = 1'($urandom);
                    cfg_if.cfg_data  = NC'($urandom);
                    ccff_tail        = NC'($urandom);
                end
            end
        end
        start = 1'b0;
        if (!finished) check("load_timeout", 0, 1);
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        words[0] = 12'hA5A; words[1] = 12'h5A5; words[2] = 12'hFFF; words[3] = 12'h001;
        run_load(-1, 0, -1, '0, -1, 0);          // plain load from IDLE
        run_load(1, 3, -1, '0, -1, 0);           // 3-cycle stall after bit 1, start from DONE
        run_load(-1, 0, 2, 12'h001, -1, 0);      // nonzero tail at bit-2 accept
        run_load(-1, 0, -1, '0, -1, 0);          // error cleared by fresh start
        run_load(-1, 0, -1, '0, -1, 2);          // reset during SHIFT_HI of bit 2
        run_load(-1, 0, -1, '0, -1, 0);          // full load after abort
        run_load(-1, 0, -1, '0, int'(P) + 3, 0); // start pulsed mid-shift

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < int'(L); i++) words[i] = NC'($urandom);
            run_load($urandom_range(0, L), $urandom_range(0, 4),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, L - 1)) : -1,
                     NC'($urandom_range(1, (1 << NC) - 1)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, P + 2 * L - 1)) : -1,
                     0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
